// File: rtl/uart_mmio_hub.sv
// Multi-channel UART MMIO hub: per-channel TX/RX byte FIFOs, status,
// W1C error flags and an interrupt enable behind a single-cycle register bus.
module uart_mmio_hub #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int RISCV_WL   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic                  cmd_wr,
  input  logic [RISCV_WL-1:0]   cmd_addr,
  input  logic [RISCV_WL-1:0]   cmd_wdata,
  output logic                  rsp_valid,
  output logic [RISCV_WL-1:0]   rsp_data,
  output logic                  irq,
  output logic [NUM_CH-1:0]     tx_vld,
  input  logic [NUM_CH-1:0]     tx_rdy,
  output logic [8*NUM_CH-1:0]   tx_data,
  input  logic [NUM_CH-1:0]     rx_valid,
  input  logic [8*NUM_CH-1:0]   rx_data
);

  localparam int AW = $clog2(NUM_CH*4);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [AW-1:0] w_word;
  logic [AW-1:0] w_ch_idx;
  logic [1:0]    w_reg;
  logic          w_ch_ok;
  logic          w_rd;
  logic          w_unused;

  assign w_word   = cmd_addr[AW+1:2];
  assign w_ch_idx = w_word >> 2;
  assign w_reg    = w_word[1:0];
  assign w_ch_ok  = int'(w_ch_idx) < NUM_CH;
  assign w_rd     = cmd_valid & ~cmd_wr;
  assign w_unused = ^{cmd_addr[RISCV_WL-1:AW+2], cmd_addr[1:0],
                      cmd_wdata[RISCV_WL-1:8]};

  logic [NUM_CH-1:0]               w_sel;
  logic [NUM_CH-1:0]               w_irq_ch;
  logic [NUM_CH-1:0][RISCV_WL-1:0] w_stat;
  logic [NUM_CH-1:0][RISCV_WL-1:0] w_rxd;
  logic [NUM_CH-1:0][RISCV_WL-1:0] w_ien;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0]    r_tx_mem [FIFO_DEPTH];
    logic [7:0]    r_rx_mem [FIFO_DEPTH];
    logic [PW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic          r_ovr, r_txo;
    logic [2:0]    r_ien;

    logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_ok;
    logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ok;
    logic w_st_wr, w_ien_wr;

    assign w_sel[g]   = w_ch_ok && (int'(w_ch_idx) == g);
    assign w_st_wr    = w_sel[g] & cmd_valid & cmd_wr & (w_reg == 2'd2);
    assign w_ien_wr   = w_sel[g] & cmd_valid & cmd_wr & (w_reg == 2'd3);

    assign w_tx_empty = r_tx_cnt == '0;
    assign w_tx_full  = r_tx_cnt == CW'(FIFO_DEPTH);
    assign w_tx_pop   = ~w_tx_empty & tx_rdy[g];
    assign w_tx_push  = w_sel[g] & cmd_valid & cmd_wr & (w_reg == 2'd0);
    assign w_tx_ok    = w_tx_push & (~w_tx_full | w_tx_pop);

    assign w_rx_empty = r_rx_cnt == '0;
    assign w_rx_full  = r_rx_cnt == CW'(FIFO_DEPTH);
    assign w_rx_pop   = w_sel[g] & w_rd & (w_reg == 2'd1) & ~w_rx_empty;
    assign w_rx_push  = rx_valid[g];
    assign w_rx_ok    = w_rx_push & (~w_rx_full | w_rx_pop);

    assign tx_vld[g]         = ~w_tx_empty;
    assign tx_data[8*g +: 8] = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
      if (w_tx_ok) r_tx_mem[r_tx_wp] <= cmd_wdata[7:0];
      if (w_rx_ok) r_rx_mem[r_rx_wp] <= rx_data[8*g +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_tx_wp  <= '0;
        r_tx_rp  <= '0;
        r_tx_cnt <= '0;
        r_rx_wp  <= '0;
        r_rx_rp  <= '0;
        r_rx_cnt <= '0;
        r_ovr    <= 1'b0;
        r_txo    <= 1'b0;
        r_ien    <= '0;
      end else begin
        if (w_tx_ok)  r_tx_wp <= r_tx_wp + PW'(1);
        if (w_tx_pop) r_tx_rp <= r_tx_rp + PW'(1);
        r_tx_cnt <= r_tx_cnt + CW'(w_tx_ok) - CW'(w_tx_pop);
        if (w_rx_ok)  r_rx_wp <= r_rx_wp + PW'(1);
        if (w_rx_pop) r_rx_rp <= r_rx_rp + PW'(1);
        r_rx_cnt <= r_rx_cnt + CW'(w_rx_ok) - CW'(w_rx_pop);
        // a new error in the same cycle as its W1C clear is kept
        if (w_rx_push & ~w_rx_ok)          r_ovr <= 1'b1;
        else if (w_st_wr & cmd_wdata[4])   r_ovr <= 1'b0;
        if (w_tx_push & ~w_tx_ok)          r_txo <= 1'b1;
        else if (w_st_wr & cmd_wdata[5])   r_txo <= 1'b0;
        if (w_ien_wr) r_ien <= cmd_wdata[2:0];
      end
    end

    assign w_stat[g] = RISCV_WL'({8'h00, 8'(r_rx_cnt), 8'(r_tx_cnt),
                                  2'b00, r_txo, r_ovr, w_rx_full,
                                  w_rx_empty, w_tx_full, w_tx_empty});
    assign w_rxd[g]  = w_rx_empty ? '0 :
                       (RISCV_WL'(r_rx_mem[r_rx_rp]) |
                        {1'b1, {(RISCV_WL-1){1'b0}}});
    assign w_ien[g]  = RISCV_WL'(r_ien);
    assign w_irq_ch[g] = |(r_ien & {r_ovr | r_txo, w_tx_empty, ~w_rx_empty});
  end

  logic [RISCV_WL-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel[c]) begin
        case (w_reg)
          2'd1:    w_rd_data = w_rxd[c];
          2'd2:    w_rd_data = w_stat[c];
          2'd3:    w_rd_data = w_ien[c];
          default: w_rd_data = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      irq       <= 1'b0;
    end else begin
      rsp_valid <= w_rd;
      rsp_data  <= w_rd ? w_rd_data : '0;
      irq       <= |w_irq_ch;
    end
  end

endmodule

// File: tb/tb_uart_mmio_hub.sv
// Bench for uart_mmio_hub: register table plus FIFO/IRQ/reset sequences,
// read responses checked through an expected-value queue.
module tb_uart_mmio_hub;

  localparam int NCH = 3;
  localparam int DEP = 4;
  localparam int WL  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_wr;
  logic [WL-1:0]     cmd_addr, cmd_wdata;
  logic              rsp_valid;
  logic [WL-1:0]     rsp_data;
  logic              irq;
  logic [NCH-1:0]    tx_vld, tx_rdy;
  logic [8*NCH-1:0]  tx_data;
  logic [NCH-1:0]    rx_valid;
  logic [8*NCH-1:0]  rx_data;

  uart_mmio_hub #(.NUM_CH(NCH), .FIFO_DEPTH(DEP), .RISCV_WL(WL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .irq(irq),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rsp_t;

  int   n_vec = 0;
  int   n_bad = 0;
  rsp_t exp_q[$];
  vec_t vt [22];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp_unexpected: got %h want none", rsp_data);
      end else begin
        rsp_t r;
        r = exp_q.pop_front();
        chk($sformatf("rsp@%h", r.addr), rsp_data, r.exp);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    rsp_t r;
    r.addr = a; r.exp = e;
    exp_q.push_back(r);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic rx_pulse(input int ch, input logic [7:0] b);
    rx_valid[ch] = 1'b1;
    rx_data[8*ch +: 8] = b;
    @(posedge clk); #1;
    rx_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    tx_rdy = '0; rx_valid = '0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_tx_vld", 32'(tx_vld), 32'h0);

    vt = '{
      '{1'b0, 32'h08, 32'h0000_0005},
      '{1'b0, 32'h18, 32'h0000_0005},
      '{1'b0, 32'h28, 32'h0000_0005},
      '{1'b0, 32'h0C, 32'h0000_0000},
      '{1'b1, 32'h0C, 32'hFFFF_FFFF},
      '{1'b0, 32'h0C, 32'h0000_0007},
      '{1'b1, 32'h0C, 32'h0000_0000},
      '{1'b0, 32'h0C, 32'h0000_0000},
      '{1'b0, 32'h04, 32'h0000_0000},
      '{1'b1, 32'h30, 32'h0000_00AA},
      '{1'b0, 32'h38, 32'h0000_0000},
      '{1'b0, 32'h30, 32'h0000_0000},
      '{1'b1, 32'h3C, 32'h0000_0007},
      '{1'b0, 32'h3C, 32'h0000_0000},
      '{1'b1, 32'h20, 32'h0000_0033},
      '{1'b0, 32'h28, 32'h0000_0104},
      '{1'b0, 32'h20, 32'h0000_0000},
      '{1'b0, 32'h08, 32'h0000_0005},
      '{1'b0, 32'h00, 32'h0000_0000},
      '{1'b1, 32'h18, 32'hFFFF_FFFF},
      '{1'b0, 32'h18, 32'h0000_0005},
      '{1'b0, 32'h34, 32'h0000_0000}
    };
    for (int i = 0; i < 22; i++) begin
      if (vt[i].wr) wr(vt[i].addr, vt[i].data);
      else          rd(vt[i].addr, vt[i].data);
    end
    @(posedge clk); #1;
    chk("tbl_irq", 32'(irq), 32'h0);
    chk("tbl_tx_vld", 32'(tx_vld), 32'h4);
    chk("tbl_ch2_data", 32'(tx_data[23:16]), 32'h33);

    // TX ordering on ch0, ch2 drains alongside
    wr(32'h00, 32'h41);
    wr(32'h00, 32'h42);
    chk("tx_first", 32'(tx_data[7:0]), 32'h41);
    chk("tx_vld_pre", 32'(tx_vld), 32'h5);
    tx_rdy = 3'b101;
    @(posedge clk); #1;
    chk("tx_second", 32'(tx_data[7:0]), 32'h42);
    chk("tx_vld_mid", 32'(tx_vld), 32'h1);
    @(posedge clk); #1;
    chk("tx_vld_done", 32'(tx_vld), 32'h0);
    tx_rdy = '0;
    rd(32'h08, 32'h0000_0005);

    // RX single byte on ch1
    rx_pulse(1, 8'h5A);
    rd(32'h14, 32'h8000_005A);
    rd(32'h14, 32'h0000_0000);

    // RX overrun on ch0, W1C clear
    for (int i = 0; i <= DEP; i++) rx_pulse(0, 8'(8'h10 + i));
    rd(32'h08, 32'h0004_0019);
    wr(32'h08, 32'h0000_0010);
    rd(32'h08, 32'h0004_0009);

    // full RX FIFO: pop and push in one cycle, order across wrap
    exp_q.push_back('{32'h04, 32'h8000_0010});
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h04;
    rx_valid[0] = 1'b1; rx_data[7:0] = 8'h20;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rx_valid = '0;
    rd(32'h08, 32'h0004_0009);
    rd(32'h04, 32'h8000_0011);
    rd(32'h04, 32'h8000_0012);
    rd(32'h04, 32'h8000_0013);
    rd(32'h04, 32'h8000_0020);
    rd(32'h08, 32'h0000_0005);

    // RX-not-empty interrupt on ch1
    wr(32'h1C, 32'h1);
    chk("irq_idle", 32'(irq), 32'h0);
    rx_pulse(1, 8'h77);
    @(posedge clk); #1;
    chk("irq_rx_set", 32'(irq), 32'h1);
    rd(32'h14, 32'h8000_0077);
    @(posedge clk); #1;
    chk("irq_rx_clr", 32'(irq), 32'h0);

    // TX overflow, error IRQ, reset mid-transfer
    for (int i = 0; i <= DEP; i++) wr(32'h00, 32'(8'hA0 + i));
    rd(32'h08, 32'h0000_0426);
    wr(32'h0C, 32'h4);
    @(posedge clk); #1;
    chk("irq_err", 32'(irq), 32'h1);
    chk("tx_vld_full", 32'(tx_vld), 32'h1);
    tx_rdy = 3'b001;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_vld", 32'(tx_vld), 32'h0);
    chk("rst_async_irq", 32'(irq), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tx_rdy = '0;
    rd(32'h08, 32'h0000_0005);
    rd(32'h1C, 32'h0000_0000);
    @(posedge clk); #1;
    chk("post_rst_irq", 32'(irq), 32'h0);
    chk("post_rst_vld", 32'(tx_vld), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("q_drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_mmio_hub.md
UART_MMIO_HUB -- requirements
Module: uart_mmio_hub

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, the number of UART channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, the per-direction FIFO depth (power of 2, 2..128).
REQ-003 SHALL have parameter RISCV_WL, default 32, the bus data width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, the bus access strobe; the block is always ready.
REQ-007 SHALL have port cmd_wr, input, 1, where 1 is write and 0 is read.
REQ-008 SHALL have port cmd_addr, input, RISCV_WL, the byte address; only bits [$clog2(NUM_CH*4)+1:2] are decoded.
REQ-009 SHALL have port cmd_wdata, input, RISCV_WL, the write data.
REQ-010 SHALL have port rsp_valid, output, 1, the read-response strobe.
REQ-011 SHALL have port rsp_data, output, RISCV_WL, the read data.
REQ-012 SHALL have port irq, output, 1, the OR of all enabled channel interrupt conditions.
REQ-013 SHALL have port tx_vld, output, NUM_CH, the per-channel byte-valid to the UART transmitter.
REQ-014 SHALL have port tx_rdy, input, NUM_CH, the per-channel transmitter ready.
REQ-015 SHALL have port tx_data, output, 8*NUM_CH, where channel c uses bits [8c+7:8c].
REQ-016 SHALL have port rx_valid, input, NUM_CH, a one-cycle received-byte pulse.
REQ-017 SHALL have port rx_data, input, 8*NUM_CH, where channel c uses bits [8c+7:8c].

Function
REQ-018 SHALL decode the word index w as channel c = w/4 and register r = w%4: 0 TX_DATA, 1 RX_DATA, 2 STATUS, 3 IRQ_EN.
REQ-019 SHALL return rsp_data one cycle after a read command, with rsp_valid = registered (cmd_valid & !cmd_wr), reflecting register state before that command's side effects.
REQ-020 SHALL, on a TX_DATA write, push cmd_wdata[7:0] into TX FIFO c; if the FIFO is full, drop the byte and set sticky tx_overflow.
REQ-021 SHALL return the count-stable value 0 on a TX_DATA read.
REQ-022 SHALL, on an RX_DATA read of a non-empty FIFO, return {1'b1, 23'b0, head byte} and pop; when empty, return 0 and not pop.
REQ-023 SHALL define STATUS read bits as: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] rx_overrun, [5] tx_overflow, [15:8] tx_count, [23:16] rx_count, all others 0.
REQ-024 SHALL, on a STATUS write, clear rx_overrun if wdata[4]=1 and clear tx_overflow if wdata[5]=1 (W1C); all other bits are ignored.
REQ-025 SHALL define IRQ_EN bits [2:0] as read/write, with bit0 = rx_not_empty, bit1 = tx_empty, bit2 = any sticky error; other bits read 0.
REQ-026 SHALL drive irq = OR over channels of (IRQ_EN & {errors, tx_empty, !rx_empty}), registered, with one cycle of latency.
REQ-027 SHALL make accesses to channels >= NUM_CH read 0 and have no effect on writes.
REQ-028 SHALL drive tx_vld[c] = TX FIFO c non-empty, with tx_data[c] = FIFO head, and pop on tx_vld & tx_rdy.
REQ-029 SHALL push rx_data[c] into RX FIFO c on an rx_valid[c] pulse; if the FIFO is full and not popped in the same cycle, drop the byte and set rx_overrun.
REQ-030 SHALL, on a simultaneous push and pop on one FIFO, perform both with the count unchanged; when full, the pop frees the slot so the push succeeds with no error flag.
REQ-031 SHALL implement FIFO pointers as modulo FIFO_DEPTH wrap-around with a separate count of width $clog2(FIFO_DEPTH+1).
REQ-032 SHALL keep channels independent, with no cross-channel effects.

Reset
REQ-033 SHALL, on reset assertion, asynchronously clear all FIFOs, counts, sticky flags, IRQ_EN, rsp_valid, rsp_data, irq, and tx_vld to 0, discarding any data in flight.
REQ-034 SHALL, for a reset asserted mid-transfer, drop tx_vld immediately; the block SHALL resume normal operation on the first clock edge after deassertion.

Verification
REQ-035 SHALL be verified by this scenario: write 0x41, 0x42 to ch0 TX_DATA, tx_rdy=1 -> tx_data 0x41 then 0x42 on consecutive handshakes, then tx_vld=0 and STATUS[0]=1.
REQ-036 SHALL be verified by this scenario: pulse rx_valid[1] with 0x5A, then read ch1 RX_DATA -> 0x8000005A; a second read -> 0x00000000.
REQ-037 SHALL be verified by this scenario: push FIFO_DEPTH+1 RX bytes on ch0 -> STATUS rx_full=1, rx_overrun=1, rx_count=FIFO_DEPTH; write STATUS 0x10 -> overrun=0.
REQ-038 SHALL be verified by this scenario: full RX FIFO, rx_valid coincident with an RX_DATA read -> no overrun, count stays FIFO_DEPTH, and the byte order is preserved across pointer wrap.
REQ-039 SHALL be verified by this scenario: IRQ_EN ch1 = 0x1, RX byte arrives -> irq=1 the cycle after the push; reading the byte out -> irq=0.
REQ-040 SHALL be verified by this scenario: fill TX FIFO, assert reset mid-transfer -> tx_vld=0, STATUS reads 0x00000005, and irq=0 after release.
